game_flow_controller: RTL

- Parametrised top-level game-flow FSM for the Galaga design; next generation of the start/play/gameover sequencer.
- Adds multi-level progression, a lives counter, pause/resume, a timed level-intro banner phase, and a victory outcome.
- Keypress detection is edge-based: a held key fires exactly one event.
- Drives the renderer and gameplay blocks with one-hot phase flags plus level/lives counts.

---
 rtl/game_pkg.sv | 17 +
 rtl/key_edge_detect.sv | 23 ++
 rtl/game_flow_controller.sv | 139 +++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state encoding and keycode constants for the game flow controller
package game_pkg;

    typedef enum logic [2:0] {
        START    = 3'd0,
        INTRO    = 3'd1,
        PLAY     = 3'd2,
        PAUSED   = 3'd3,
        GAMEOVER = 3'd4,
        VICTORY  = 3'd5
    } game_state_t;

    localparam logic [7:0] KEY_ENTER = 8'h28;
    localparam logic [7:0] KEY_P     = 8'h13;
    localparam logic [7:0] KEY_NONE  = 8'h00;

endpackage

// File: rtl/key_edge_detect.sv
// rtl/key_edge_detect.sv - one-cycle press pulse when keycode first matches KEY
module key_edge_detect
    import game_pkg::*;
#(
    parameter logic [7:0] KEY = KEY_ENTER
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    output logic       press
);

    logic [7:0] r_key_prev;

    always_ff @(posedge Clk) begin
        if (Reset) r_key_prev <= KEY_NONE;
        else       r_key_prev <= keycode;
    end

    // A held key fires once; it must leave KEY before it can fire again.
    assign press = (keycode == KEY) && (r_key_prev != KEY);

endmodule

// File: rtl/game_flow_controller.sv
// rtl/game_flow_controller.sv - title/intro/play/pause/gameover/victory sequencer with level and lives tracking
module game_flow_controller
    import game_pkg::*;
#(
    parameter logic [7:0] START_KEY    = KEY_ENTER,
    parameter logic [7:0] PAUSE_KEY    = KEY_P,
    parameter int         NUM_LIVES    = 3,
    parameter int         NUM_LEVELS   = 4,
    parameter int         INTRO_CYCLES = 50_000_000,
    localparam int        LW = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1,
    localparam int        VW = $clog2(NUM_LIVES + 1)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic [7:0]    keycode,
    input  logic          ship_hit,
    input  logic          wave_clear,
    output logic          start,
    output logic          intro,
    output logic          play,
    output logic          paused,
    output logic          gameover,
    output logic          victory,
    output logic [LW-1:0] level,
    output logic [VW-1:0] lives
);

    localparam int CW = (INTRO_CYCLES > 1) ? $clog2(INTRO_CYCLES) : 1;
    localparam logic [CW-1:0] INTRO_LOAD = CW'(INTRO_CYCLES - 1);
    localparam logic [LW-1:0] LAST_LEVEL = LW'(NUM_LEVELS - 1);
    localparam logic [VW-1:0] FULL_LIVES = VW'(NUM_LIVES);

    game_state_t   r_state, w_state_nxt;
    logic [LW-1:0] r_level, w_level_nxt;
    logic [VW-1:0] r_lives, w_lives_nxt;
    logic [CW-1:0] r_cnt,   w_cnt_nxt;
    logic          w_press_start, w_press_pause;

    key_edge_detect #(.KEY(START_KEY)) u_start_key (
        .Clk     (Clk),
        .Reset   (Reset),
        .keycode (keycode),
        .press   (w_press_start)
    );

    key_edge_detect #(.KEY(PAUSE_KEY)) u_pause_key (
        .Clk     (Clk),
        .Reset   (Reset),
        .keycode (keycode),
        .press   (w_press_pause)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= START;
            r_level <= '0;
            r_lives <= FULL_LIVES;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_level <= w_level_nxt;
            r_lives <= w_lives_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_level_nxt = r_level;
        w_lives_nxt = r_lives;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            START: begin
                if (w_press_start) begin
                    w_state_nxt = INTRO;
                    w_level_nxt = '0;
                    w_lives_nxt = FULL_LIVES;
                    w_cnt_nxt   = INTRO_LOAD;
                end
            end
            INTRO: begin
                if (r_cnt == '0) w_state_nxt = PLAY;
                else             w_cnt_nxt   = r_cnt - CW'(1);
            end
            PLAY: begin
                // A hit takes precedence; a clear in the same cycle is dropped.
                if (ship_hit) begin
                    if (r_lives <= VW'(1)) begin
                        w_state_nxt = GAMEOVER;
                        w_lives_nxt = '0;
                    end else begin
                        w_state_nxt = INTRO;
                        w_lives_nxt = r_lives - VW'(1);
                        w_cnt_nxt   = INTRO_LOAD;
                    end
                end else if (wave_clear) begin
                    if (r_level >= LAST_LEVEL) begin
                        w_state_nxt = VICTORY;
                    end else begin
                        w_state_nxt = INTRO;
                        w_level_nxt = r_level + LW'(1);
                        w_cnt_nxt   = INTRO_LOAD;
                    end
                end else if (w_press_pause) begin
                    w_state_nxt = PAUSED;
                end
            end
            PAUSED: begin
                if (w_press_pause) w_state_nxt = PLAY;
            end
            GAMEOVER, VICTORY: begin
                if (w_press_start) w_state_nxt = START;
            end
            default: w_state_nxt = START;
        endcase
    end

    always_comb begin
        start    = 1'b0;
        intro    = 1'b0;
        play     = 1'b0;
        paused   = 1'b0;
        gameover = 1'b0;
        victory  = 1'b0;
        case (r_state)
            START:    start    = 1'b1;
            INTRO:    intro    = 1'b1;
            PLAY:     play     = 1'b1;
            PAUSED:   paused   = 1'b1;
            GAMEOVER: gameover = 1'b1;
            VICTORY:  victory  = 1'b1;
            default:  start    = 1'b1;
        endcase
    end

    assign level = r_level;
    assign lives = r_lives;

endmodule
